// File: rtl/mem_stage_lsu.sv
// Load/store unit between the pipeline memory stage and the data cache.
// Accepts one op at a time, checks alignment, drives the cache and returns an extended result.
module mem_stage_lsu #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int RD_WIDTH   = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic                  req_store,
  input  logic [RD_WIDTH-1:0]   req_rd,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [RD_WIDTH-1:0]   resp_rd,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic                  resp_misaligned,
  output logic [ADDR_WIDTH-1:0] dc_addr,
  output logic [DATA_WIDTH-1:0] dc_wdata,
  output logic [1:0]            dc_wlen,
  output logic                  dc_enable,
  output logic                  dc_wrn,
  input  logic [DATA_WIDTH-1:0] dc_rdata,
  input  logic                  dc_valid,
  input  logic                  dc_write_done,
  output logic [CNT_WIDTH-1:0]  stat_loads,
  output logic [CNT_WIDTH-1:0]  stat_stores,
  output logic [CNT_WIDTH-1:0]  stat_stall
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [1:0]            size_reg;
  logic                  unsigned_reg;
  logic                  store_reg;
  logic [RD_WIDTH-1:0]   rd_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  misaligned_reg;
  logic [CNT_WIDTH-1:0]  loads_reg, stores_reg, stall_reg;

  logic                  req_misaligned;
  logic                  access_done;
  logic [DATA_WIDTH-1:0] load_ext;

  // Byte, half and word lanes of the returned cache word
  logic [7:0]  byte_lane [8];
  logic [15:0] half_lane [4];
  logic [31:0] word_lane [2];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_byte
      assign byte_lane[gi] = dc_rdata[8*gi +: 8];
    end
    for (gi = 0; gi < 4; gi++) begin : g_half
      assign half_lane[gi] = dc_rdata[16*gi +: 16];
    end
    for (gi = 0; gi < 2; gi++) begin : g_word
      assign word_lane[gi] = dc_rdata[32*gi +: 32];
    end
  endgenerate

  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      2'd0: req_misaligned = 1'b0;
      2'd1: req_misaligned = req_addr[0];
      2'd2: req_misaligned = |req_addr[1:0];
      2'd3: req_misaligned = |req_addr[2:0];
      default: req_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    b = byte_lane[addr_reg[2:0]];
    h = half_lane[addr_reg[2:1]];
    w = word_lane[addr_reg[2]];
    load_ext = dc_rdata;
    case (size_reg)
      2'd0: load_ext = unsigned_reg ? {{(DATA_WIDTH-8){1'b0}}, b}
                                    : {{(DATA_WIDTH-8){b[7]}}, b};
      2'd1: load_ext = unsigned_reg ? {{(DATA_WIDTH-16){1'b0}}, h}
                                    : {{(DATA_WIDTH-16){h[15]}}, h};
      2'd2: load_ext = unsigned_reg ? {{(DATA_WIDTH-32){1'b0}}, w}
                                    : {{(DATA_WIDTH-32){w[31]}}, w};
      default: load_ext = dc_rdata;
    endcase
  end

  // Only the strobe that matches the op type completes the access
  assign access_done = store_reg ? dc_write_done : dc_valid;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = req_misaligned ? RESP : ACCESS;
      ACCESS:  if (access_done) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_reg == IDLE);
    dc_enable  = (state_reg == ACCESS);
    dc_wrn     = (state_reg == ACCESS) && store_reg;
    resp_valid = (state_reg == RESP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_reg       <= '0;
      wdata_reg      <= '0;
      size_reg       <= '0;
      unsigned_reg   <= 1'b0;
      store_reg      <= 1'b0;
      rd_reg         <= '0;
      data_reg       <= '0;
      misaligned_reg <= 1'b0;
      loads_reg      <= '0;
      stores_reg     <= '0;
      stall_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            addr_reg       <= req_addr;
            wdata_reg      <= req_wdata;
            size_reg       <= req_size;
            unsigned_reg   <= req_unsigned;
            store_reg      <= req_store;
            rd_reg         <= req_rd;
            data_reg       <= '0;
            misaligned_reg <= req_misaligned;
          end
        end
        ACCESS: begin
          if (access_done) begin
            if (store_reg) begin
              data_reg   <= '0;
              stores_reg <= sat_inc(stores_reg);
            end else begin
              data_reg  <= load_ext;
              loads_reg <= sat_inc(loads_reg);
            end
          end else begin
            stall_reg <= sat_inc(stall_reg);
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_data       = data_reg;
  assign resp_rd         = rd_reg;
  assign resp_addr       = addr_reg;
  assign resp_misaligned = misaligned_reg;
  assign dc_addr         = addr_reg;
  assign dc_wdata        = wdata_reg;
  assign dc_wlen         = size_reg;
  assign stat_loads      = loads_reg;
  assign stat_stores     = stores_reg;
  assign stat_stall      = stall_reg;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu; counters are narrowed to 4 bits so saturation is reachable.
module tb_mem_stage_lsu;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned, req_store;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_data, resp_addr;
  logic [4:0]  resp_rd;
  logic        resp_misaligned;
  logic [63:0] dc_addr, dc_wdata, dc_rdata;
  logic [1:0]  dc_wlen;
  logic        dc_enable, dc_wrn, dc_valid, dc_write_done;
  logic [CW-1:0] stat_loads, stat_stores, stat_stall;

  int total = 0;
  int bad = 0;

  mem_stage_lsu #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .RD_WIDTH(5), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_store(req_store), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_addr(resp_addr), .resp_misaligned(resp_misaligned),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_wlen(dc_wlen),
    .dc_enable(dc_enable), .dc_wrn(dc_wrn), .dc_rdata(dc_rdata),
    .dc_valid(dc_valid), .dc_write_done(dc_write_done),
    .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a request for one cycle; returns #1 after the accepting edge
  task automatic issue(input logic [63:0] a, input logic [1:0] s, input logic u,
                       input logic st, input logic [63:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_addr = a; req_size = s; req_unsigned = u;
    req_store = st; req_wdata = wd; req_rd = rd;
    tick();
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    total++; if (dc_enable !== 1'b0 || dc_wrn !== 1'b0 || dc_addr !== 64'h0) begin bad++; $display("FAIL reset_dc got=%b/%b/%h exp=0/0/0", dc_enable, dc_wrn, dc_addr); end
    total++; if ({stat_loads, stat_stores, stat_stall} !== '0) begin bad++; $display("FAIL reset_counters got=%h/%h/%h exp=0/0/0", stat_loads, stat_stores, stat_stall); end
    $display("reset done");
  endtask

  task automatic test_load_hit();
    issue(64'h1003, 2'd0, 1'b0, 1'b0, 64'h0, 5'd7);
    total++; if (dc_enable !== 1'b1 || dc_wrn !== 1'b0) begin bad++; $display("FAIL hit_dc_enable got=%b/%b exp=1/0", dc_enable, dc_wrn); end
    total++; if (dc_addr !== 64'h1003 || dc_wlen !== 2'd0) begin bad++; $display("FAIL hit_dc_addr got=%h/%0d exp=1003/0", dc_addr, dc_wlen); end
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin bad++; $display("FAIL hit_t1 got=%b/%b exp=0/0", resp_valid, req_ready); end
    dc_valid = 1'b1; dc_rdata = 64'h0000_0000_8000_0000;
    tick();
    dc_valid = 1'b0; dc_rdata = '0;
    total++; if (resp_valid !== 1'b1 || dc_enable !== 1'b0) begin bad++; $display("FAIL hit_t2 got=%b/%b exp=1/0", resp_valid, dc_enable); end
    total++; if (resp_data !== 64'hFFFF_FFFF_FFFF_FF80) begin bad++; $display("FAIL hit_data got=%h exp=ffffffffffffff80", resp_data); end
    total++; if (resp_rd !== 5'd7 || resp_addr !== 64'h1003 || resp_misaligned !== 1'b0) begin bad++; $display("FAIL hit_fields got=%0d/%h/%b exp=7/1003/0", resp_rd, resp_addr, resp_misaligned); end
    total++; if (stat_loads !== 4'd1) begin bad++; $display("FAIL hit_loads got=%0d exp=1", stat_loads); end
    $display("load addr=1003 size=0 data=%h", resp_data);
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL hit_idle got=%b/%b exp=1/0", req_ready, resp_valid); end
  endtask

  task automatic test_load_extend();
    issue(64'h1003, 2'd0, 1'b1, 1'b0, 64'h0, 5'd1);
    dc_valid = 1'b1; dc_rdata = 64'h0000_0000_8000_0000;
    tick(); dc_valid = 1'b0;
    total++; if (resp_data !== 64'h80) begin bad++; $display("FAIL ext_byte_u got=%h exp=80", resp_data); end
    $display("load addr=1003 size=0 unsigned data=%h", resp_data);
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    issue(64'h1004, 2'd2, 1'b0, 1'b0, 64'h0, 5'd2);
    dc_valid = 1'b1; dc_rdata = 64'hDEAD_BEEF_0000_0001;
    tick(); dc_valid = 1'b0;
    total++; if (resp_data !== 64'hFFFF_FFFF_DEAD_BEEF) begin bad++; $display("FAIL ext_word_s got=%h exp=ffffffffdeadbeef", resp_data); end
    total++; if (stat_loads !== 4'd3) begin bad++; $display("FAIL ext_loads got=%0d exp=3", stat_loads); end
    $display("load addr=1004 size=2 data=%h", resp_data);
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
  endtask

  task automatic test_store_miss();
    int en_cycles = 0;
    issue(64'h2000, 2'd3, 1'b0, 1'b1, 64'h1122_3344_5566_7788, 5'd3);
    for (int i = 0; i < 10; i++) begin
      dc_valid = (i == 4);
      dc_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      if (dc_enable) en_cycles++;
      total++; if (dc_wrn !== 1'b1 || dc_addr !== 64'h2000 || dc_wdata !== 64'h1122_3344_5566_7788 || dc_wlen !== 2'd3) begin
        bad++; $display("FAIL store_hold cyc=%0d got=%b/%h/%h/%0d exp=1/2000/1122334455667788/3", i, dc_wrn, dc_addr, dc_wdata, dc_wlen);
      end
      tick();
    end
    dc_valid = 1'b0; dc_rdata = '0;
    dc_write_done = 1'b1;
    if (dc_enable) en_cycles++;
    tick();
    dc_write_done = 1'b0;
    total++; if (en_cycles !== 11) begin bad++; $display("FAIL store_en_cycles got=%0d exp=11", en_cycles); end
    total++; if (dc_enable !== 1'b0 || resp_valid !== 1'b1) begin bad++; $display("FAIL store_done got=%b/%b exp=0/1", dc_enable, resp_valid); end
    total++; if (resp_data !== 64'h0) begin bad++; $display("FAIL store_data got=%h exp=0", resp_data); end
    total++; if (stat_stall !== 4'd10 || stat_stores !== 4'd1 || stat_loads !== 4'd3) begin bad++; $display("FAIL store_counters got=%0d/%0d/%0d exp=10/1/3", stat_stall, stat_stores, stat_loads); end
    $display("store addr=2000 size=3 stall=%0d", stat_stall);
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    issue(64'h1002, 2'd2, 1'b0, 1'b0, 64'h0, 5'd4);
    total++; if (resp_valid !== 1'b1 || resp_misaligned !== 1'b1 || resp_data !== 64'h0) begin bad++; $display("FAIL mis_word got=%b/%b/%h exp=1/1/0", resp_valid, resp_misaligned, resp_data); end
    total++; if (dc_enable !== 1'b0) begin bad++; $display("FAIL mis_dc_enable got=%b exp=0", dc_enable); end
    $display("misaligned addr=1002 size=2");
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    issue(64'h2004, 2'd3, 1'b0, 1'b1, 64'h55, 5'd5);
    total++; if (resp_valid !== 1'b1 || resp_misaligned !== 1'b1 || dc_enable !== 1'b0) begin bad++; $display("FAIL mis_dword got=%b/%b/%b exp=1/1/0", resp_valid, resp_misaligned, dc_enable); end
    $display("misaligned addr=2004 size=3");
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    total++; if (stat_loads !== 4'd3 || stat_stores !== 4'd1 || stat_stall !== 4'd10) begin bad++; $display("FAIL mis_counters got=%0d/%0d/%0d exp=3/1/10", stat_loads, stat_stores, stat_stall); end
  endtask

  task automatic test_backpressure();
    issue(64'h1006, 2'd1, 1'b1, 1'b0, 64'h0, 5'd9);
    dc_valid = 1'b1; dc_rdata = 64'hDEAD_BEEF_0000_0001;
    tick(); dc_valid = 1'b0; dc_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      total++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== 64'hDEAD || resp_rd !== 5'd9 || resp_addr !== 64'h1006 || resp_misaligned !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b/%b/%h/%0d/%h/%b exp=1/0/dead/9/1006/0", i, resp_valid, req_ready, resp_data, resp_rd, resp_addr, resp_misaligned);
      end
      tick();
    end
    $display("load addr=1006 size=1 unsigned data=%h held 5 cycles", resp_data);
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b/%b exp=1/0", req_ready, resp_valid); end
  endtask

  task automatic test_saturate();
    issue(64'h3000, 2'd3, 1'b1, 1'b0, 64'h0, 5'd11);
    for (int i = 0; i < 20; i++) tick();
    dc_valid = 1'b1; dc_rdata = 64'h8000_0000_0000_0001;
    tick(); dc_valid = 1'b0; dc_rdata = '0;
    total++; if (stat_stall !== 4'd15) begin bad++; $display("FAIL sat_stall got=%0d exp=15", stat_stall); end
    total++; if (resp_data !== 64'h8000_0000_0000_0001 || stat_loads !== 4'd5) begin bad++; $display("FAIL sat_load got=%h/%0d exp=8000000000000001/5", resp_data, stat_loads); end
    $display("load addr=3000 size=3 stall=%0d", stat_stall);
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    issue(64'h4000, 2'd3, 1'b0, 1'b0, 64'h0, 5'd12);
    total++; if (dc_enable !== 1'b1) begin bad++; $display("FAIL rst_pre_enable got=%b exp=1", dc_enable); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    total++; if (dc_enable !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid got=%b/%b/%b exp=0/0/1", dc_enable, resp_valid, req_ready); end
    total++; if ({stat_loads, stat_stores, stat_stall} !== '0) begin bad++; $display("FAIL rst_mid_counters got=%0d/%0d/%0d exp=0/0/0", stat_loads, stat_stores, stat_stall); end
    dc_valid = 1'b1; dc_rdata = 64'h1234;
    tick(); dc_valid = 1'b0;
    total++; if (resp_valid !== 1'b0 || stat_loads !== 4'd0) begin bad++; $display("FAIL rst_no_resp got=%b/%0d exp=0/0", resp_valid, stat_loads); end
    $display("reset during access abandoned op");
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
    req_unsigned = 1'b0; req_store = 1'b0; req_rd = '0; resp_ready = 1'b0;
    dc_rdata = '0; dc_valid = 1'b0; dc_write_done = 1'b0;
    #1;
    test_reset();
    test_load_hit();
    test_load_extend();
    test_store_miss();
    test_misaligned();
    test_backpressure();
    test_saturate();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
